f1_start_ctrl: RTL and testbench

F1_START_CTRL -- requirements
Module: f1_start_ctrl

---
 rtl/f1_start_ctrl.sv | 84 ++++++++
 tb/tb_f1_start_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/f1_start_ctrl.sv
// f1_start_ctrl: F1 start-light sequencer with randomised hold and reaction-time measurement
module f1_start_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_i,
    input  logic             tick_i,
    input  logic [6:0]       rnd_i,
    input  logic             react_i,
    output logic [WIDTH-1:0] lights_o,
    output logic             tick_en_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] react_time_o,
    output logic             result_valid_o,
    output logic             false_start_o
);
    typedef enum logic [1:0] {S_IDLE, S_SEQ, S_HOLD, S_WAIT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t           state_q;
    logic [WIDTH-1:0] lights_q;
    logic [6:0]       hold_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] react_time_q;
    logic             result_valid_q;
    logic             false_start_q;
    logic             active_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            lights_q       <= '0;
            hold_q         <= '0;
            cnt_q          <= '0;
            react_time_q   <= '0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (trigger_i) begin
                    state_q  <= S_SEQ;
                    active_q <= 1'b1;
                end
                S_SEQ, S_HOLD: if (react_i) begin
                    lights_q      <= '0;
                    false_start_q <= 1'b1;
                    active_q      <= 1'b0;
                    state_q       <= S_IDLE;
                end else if (tick_i && state_q == S_SEQ) begin
                    lights_q <= {lights_q[WIDTH-2:0], 1'b1};
                    if (&lights_q[WIDTH-2:0]) begin
                        state_q <= S_HOLD;
                        hold_q  <= (rnd_i == 7'd0) ? 7'd1 : rnd_i;
                    end
                end else if (tick_i) begin
                    hold_q <= hold_q - 7'd1;
                    if (hold_q == 7'd1) begin
                        lights_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_WAIT;
                    end
                end
                // react samples the count before this cycle's tick; a saturated count is the timeout
                default: if (react_i || cnt_q == CNT_MAX) begin
                    react_time_q   <= react_i ? cnt_q : CNT_MAX;
                    result_valid_q <= 1'b1;
                    active_q       <= 1'b0;
                    state_q        <= S_IDLE;
                end else if (tick_i) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            endcase
        end
    end
    assign lights_o       = lights_q;
    assign tick_en_o      = active_q;
    assign busy_o         = active_q;
    assign react_time_o   = react_time_q;
    assign result_valid_o = result_valid_q;
    assign false_start_o  = false_start_q;
endmodule

// File: tb/tb_f1_start_ctrl.sv
// tb_f1_start_ctrl: directed scenarios with a pulse scoreboard for result/false-start events
module tb_f1_start_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trigger_i = 1'b0, tick_i = 1'b0, react_i = 1'b0;
    logic [6:0] rnd_i = 7'd3;
    logic [7:0] lights_o;
    logic       tick_en_o, busy_o, result_valid_o, false_start_o;
    logic [3:0] react_time_o;
    typedef struct packed {logic is_res; logic [3:0] rt;} exp_t;
    exp_t exp_q[$];
    int tests = 0, fails = 0;
    logic prev_pulse = 1'b0;

    f1_start_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .trigger_i(trigger_i), .tick_i(tick_i), .rnd_i(rnd_i),
        .react_i(react_i), .lights_o(lights_o), .tick_en_o(tick_en_o), .busy_o(busy_o),
        .react_time_o(react_time_o), .result_valid_o(result_valid_o),
        .false_start_o(false_start_o)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic tk, input logic rc, input logic tg);
        tick_i = tk; react_i = rc; trigger_i = tg;
        @(posedge clk); #1;
        tick_i = 1'b0; react_i = 1'b0; trigger_i = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_idle(input string name, input logic [3:0] rt);
        chk({name, " lights"}, 16'(lights_o), 16'h0);
        chk({name, " busy"}, 16'(busy_o), 16'h0);
        chk({name, " tick_en"}, 16'(tick_en_o), 16'h0);
        chk({name, " react_time"}, 16'(react_time_o), 16'(rt));
    endtask

    // monitor: every pulse must match the next scoreboard entry
    always @(negedge clk) begin
        logic pulse;
        exp_t e;
        pulse = result_valid_o | false_start_o;
        if (pulse) begin
            chk("pulse_width", 16'(prev_pulse), 16'h0);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pulse got rv=%0b fs=%0b expected none", result_valid_o, false_start_o);
            end else begin
                e = exp_q.pop_front();
                chk("pulse", {10'd0, result_valid_o, false_start_o, react_time_o},
                    {10'd0, e.is_res, ~e.is_res, e.rt});
            end
        end
        prev_pulse = pulse;
    end

    initial begin
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        chk_idle("reset", 4'd0);
        chk("reset rv", 16'(result_valid_o), 16'h0);
        chk("reset fs", 16'(false_start_o), 16'h0);
        rst = 1'b1;
        // normal run, rnd=3, react after 5 WAIT ticks
        cyc(1'b0, 1'b0, 1'b1);
        chk("start busy", 16'(busy_o), 16'h1);
        chk("start tick_en", 16'(tick_en_o), 16'h1);
        chk("start lights", 16'(lights_o), 16'h0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk($sformatf("seq tick%0d", i), 16'(lights_o), (16'd1 << i) - 16'd1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        rnd_i = 7'd100;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("hold tick10", 16'(lights_o), 16'hff);
        cyc(1'b1, 1'b0, 1'b0);
        chk("out tick11", 16'(lights_o), 16'h0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("wait ignores trigger", 16'({busy_o, lights_o}), 16'h100);
        exp_q.push_back('{1'b1, 4'd5});
        cyc(1'b0, 1'b1, 1'b0);
        chk_idle("result", 4'd5);
        // false start at lights=07, react wins over same-cycle tick
        cyc(1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        chk("fs lights07", 16'(lights_o), 16'h7);
        exp_q.push_back('{1'b0, 4'd5});
        cyc(1'b1, 1'b1, 1'b0);
        chk_idle("false_start", 4'd5);
        cyc(1'b1, 1'b1, 1'b0);
        chk_idle("idle tick+react", 4'd5);
        // rnd=0: one hold tick, react with first WAIT tick
        rnd_i = 7'd0;
        cyc(1'b0, 1'b0, 1'b1);
        repeat (8) cyc(1'b1, 1'b0, 1'b0);
        rnd_i = 7'd9;
        cyc(1'b1, 1'b0, 1'b0);
        chk("rnd0 lights out", 16'(lights_o), 16'h0);
        exp_q.push_back('{1'b1, 4'd0});
        cyc(1'b1, 1'b1, 1'b0);
        chk_idle("rnd0 result", 4'd0);
        // timeout after 15 WAIT ticks
        rnd_i = 7'd2;
        cyc(1'b0, 1'b0, 1'b1);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        repeat (15) cyc(1'b1, 1'b0, 1'b0);
        chk("pre-timeout busy", 16'(busy_o), 16'h1);
        exp_q.push_back('{1'b1, 4'd15});
        cyc(1'b0, 1'b0, 1'b0);
        chk_idle("timeout", 4'd15);
        // reset during HOLD
        rnd_i = 7'd5;
        cyc(1'b0, 1'b0, 1'b1);
        repeat (9) cyc(1'b1, 1'b0, 1'b0);
        chk("hold lights", 16'(lights_o), 16'hff);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b1);
        chk_idle("mid reset", 4'd0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        chk_idle("tick after reset", 4'd0);
        // trigger held through a false start restarts one cycle after IDLE
        cyc(1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b1);
        chk("held seq lights", 16'(lights_o), 16'h3);
        exp_q.push_back('{1'b0, 4'd0});
        cyc(1'b0, 1'b1, 1'b1);
        chk("held idle busy", 16'(busy_o), 16'h0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("held restart busy", 16'(busy_o), 16'h1);
        cyc(1'b1, 1'b0, 1'b1);
        chk("held restart lights", 16'(lights_o), 16'h1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("scoreboard drained", 16'(exp_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
